// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared constants for the decode stage: destination-select encoding,
// instruction field positions and the immediate width.
// ---------------------------------------------------------------------------
package decode_pkg;

  // Destination register select (regdst_i); 2'b11 is reserved and decodes as rt
  localparam logic [1:0] RD_RT   = 2'b00;
  localparam logic [1:0] RD_RD   = 2'b01;
  localparam logic [1:0] RD_LINK = 2'b10;

  // Instruction layout
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FIELD_W = 5;

endpackage : decode_pkg

// File: rtl/reg_file_bypass.sv
// ---------------------------------------------------------------------------
// reg_file_bypass
// NREGS x DATA_W register file, two combinational read ports and one write
// port. Register 0 is hardwired to zero. A write in the same cycle as a read
// of the same (non-zero) index is bypassed to the read port.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears all regs)
//   i_ra1, i_ra2     read indices
//   i_we, i_wa, i_wd write enable / index / data
//   o_rd1, o_rd2     read data (combinational)
// ---------------------------------------------------------------------------
module reg_file_bypass
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_en;

  // Writes to r0 are dropped so r0 never holds anything but zero
  assign w_wr_en = i_we && (i_wa != '0);

  // Storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Read port 1: r0 forced to zero, then same-cycle write bypass, then array
  always_comb begin
    o_rd1 = r_regs[i_ra1];
    if (i_ra1 == '0) begin
      o_rd1 = '0;
    end else if (w_wr_en && (i_wa == i_ra1)) begin
      o_rd1 = i_wd;
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    o_rd2 = r_regs[i_ra2];
    if (i_ra2 == '0) begin
      o_rd2 = '0;
    end else if (w_wr_en && (i_wa == i_ra2)) begin
      o_rd2 = i_wd;
    end
  end

endmodule : reg_file_bypass

// File: rtl/decode_stage_param.sv
// ---------------------------------------------------------------------------
// decode_stage_param
// Decode stage of the 5-stage pipeline: register file read with write-back
// bypass, destination select (rt / rd / link), immediate sign-extension,
// load-use hazard detection and the ID/EX pipeline register with valid,
// stall-bubble and flush control.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_i, instr_valid_i        IF/ID instruction and its valid flag
//   regdst_i, memread_i,
//   regwrite_i                    control-unit decode for instr_i
//   flush_i                       squash: next ID/EX entry is a bubble
//   wb_we_i, wb_addr_i, wb_data_i write-back port into the register file
//   stall_o                       combinational load-use stall request
//   ex_*                          registered ID/EX pipeline outputs
// ---------------------------------------------------------------------------
module decode_stage_param
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr_i,
  input  logic                instr_valid_i,
  input  logic [1:0]          regdst_i,
  input  logic                memread_i,
  input  logic                regwrite_i,
  input  logic                flush_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic                stall_o,
  output logic                ex_valid_o,
  output logic [DATA_W-1:0]   ex_dr1_o,
  output logic [DATA_W-1:0]   ex_dr2_o,
  output logic [DATA_W-1:0]   ex_imm_o,
  output logic [ADDR_W-1:0]   ex_rs_o,
  output logic [ADDR_W-1:0]   ex_rt_o,
  output logic [ADDR_W-1:0]   ex_dest_o,
  output logic                ex_memread_o,
  output logic                ex_regwrite_o
);

  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

  // Decoded fields (low ADDR_W bits of each 5-bit index field)
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [IMM_W-1:0]  w_imm16;
  logic [DATA_W-1:0] w_imm_ext;
  logic [ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0] w_dr1;
  logic [DATA_W-1:0] w_dr2;
  logic              w_haz;
  logic              w_stall;
  logic              w_unused;

  // ID/EX pipeline register
  logic              r_valid;
  logic [DATA_W-1:0] r_dr1;
  logic [DATA_W-1:0] r_dr2;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_rs;
  logic [ADDR_W-1:0] r_rt;
  logic [ADDR_W-1:0] r_dest;
  logic              r_memread;
  logic              r_regwrite;

  assign w_rs    = instr_i[RS_LSB +: ADDR_W];
  assign w_rt    = instr_i[RT_LSB +: ADDR_W];
  assign w_rd    = instr_i[RD_LSB +: ADDR_W];
  assign w_imm16 = instr_i[IMM_LSB +: IMM_W];

  // Opcode/funct bits are decoded by the control unit, not here
  assign w_unused = &{1'b0, instr_i};

  // Sign-extension through a signed size cast (also legal when DATA_W == IMM_W)
  assign w_imm_ext = DATA_W'($signed(w_imm16));

  // Destination select; the reserved encoding falls back to rt
  always_comb begin
    w_dest = w_rt;
    unique case (regdst_i)
      RD_RD:   w_dest = w_rd;
      RD_LINK: w_dest = LINK_IDX;
      default: w_dest = w_rt;
    endcase
  end

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .i_we  (wb_we_i),
    .i_wa  (wb_addr_i),
    .i_wd  (wb_data_i),
    .o_rd1 (w_dr1),
    .o_rd2 (w_dr2)
  );

  // Load-use: a valid load in ID/EX whose target is a source of the current instruction
  assign w_haz = r_valid && r_memread && (r_dest != '0) && instr_valid_i &&
                 ((r_dest == w_rs) || (r_dest == w_rt));

  // A flush already squashes the dependent instruction, so no stall is needed
  assign w_stall = w_haz && !flush_i && !rst;
  assign stall_o = w_stall;

  // ID/EX update: reset > flush > stall bubble > load. Bubbles keep data fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_dr1      <= '0;
      r_dr2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dest     <= '0;
      r_memread  <= 1'b0;
      r_regwrite <= 1'b0;
    end else if (flush_i || w_stall) begin
      r_valid    <= 1'b0;
      r_memread  <= 1'b0;
      r_regwrite <= 1'b0;
    end else begin
      r_valid    <= instr_valid_i;
      r_dr1      <= w_dr1;
      r_dr2      <= w_dr2;
      r_imm      <= w_imm_ext;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_dest     <= w_dest;
      r_memread  <= memread_i  && instr_valid_i;
      r_regwrite <= regwrite_i && instr_valid_i;
    end
  end

  assign ex_valid_o    = r_valid;
  assign ex_dr1_o      = r_dr1;
  assign ex_dr2_o      = r_dr2;
  assign ex_imm_o      = r_imm;
  assign ex_rs_o       = r_rs;
  assign ex_rt_o       = r_rt;
  assign ex_dest_o     = r_dest;
  assign ex_memread_o  = r_memread;
  assign ex_regwrite_o = r_regwrite;

endmodule : decode_stage_param

// File: tb/tb_decode_stage_param.sv
// ---------------------------------------------------------------------------
// tb_decode_stage_param
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model (register array + ID/EX entry) kept in the bench.
// ---------------------------------------------------------------------------
module tb_decode_stage_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  regdst;
  logic        memread;
  logic        regwrite;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        stall_o;
  logic        ex_valid_o;
  logic [31:0] ex_dr1_o;
  logic [31:0] ex_dr2_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs_o;
  logic [4:0]  ex_rt_o;
  logic [4:0]  ex_dest_o;
  logic        ex_memread_o;
  logic        ex_regwrite_o;

  decode_stage_param #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .LINK_REG (31)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr),
    .instr_valid_i (instr_valid),
    .regdst_i      (regdst),
    .memread_i     (memread),
    .regwrite_i    (regwrite),
    .flush_i       (flush),
    .wb_we_i       (wb_we),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .stall_o       (stall_o),
    .ex_valid_o    (ex_valid_o),
    .ex_dr1_o      (ex_dr1_o),
    .ex_dr2_o      (ex_dr2_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rs_o       (ex_rs_o),
    .ex_rt_o       (ex_rt_o),
    .ex_dest_o     (ex_dest_o),
    .ex_memread_o  (ex_memread_o),
    .ex_regwrite_o (ex_regwrite_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers plus the expected ID/EX entry
  logic [31:0] m_regs [32];
  logic        m_valid = 1'b0, m_mr = 1'b0, m_rw = 1'b0;
  logic [31:0] m_dr1 = '0, m_dr2 = '0, m_imm = '0;
  logic [4:0]  m_rs = '0, m_rt = '0, m_dest = '0;
  logic        m_stall_last = 1'b0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic [1:0] rd_sel,
                       input logic mr, input logic rw, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    instr = ins; instr_valid = v; regdst = rd_sel; memread = mr; regwrite = rw;
    flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
  endtask

  // One clock: check stall before the edge, advance the model, check ex_* after it
  task automatic step();
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] d1, d2, imm;
    logic        haz, stl;
    #1;
    rs  = instr[25:21];
    rt  = instr[20:16];
    rd  = instr[15:11];
    imm = {{16{instr[15]}}, instr[15:0]};
    dst = (regdst == 2'b01) ? rd : (regdst == 2'b10) ? 5'd31 : rt;
    haz = m_valid && m_mr && (m_dest != 5'd0) && instr_valid && (m_dest == rs || m_dest == rt);
    stl = haz && !flush && !rst;
    check("stall_o", 32'(stall_o), 32'(stl));
    m_stall_last = stl;
    d1 = m_read(rs);
    d2 = m_read(rt);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_valid = 0; m_mr = 0; m_rw = 0; m_dr1 = 0; m_dr2 = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_dest = 0;
    end else begin
      if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (flush || stl) begin
        m_valid = 0; m_mr = 0; m_rw = 0;
      end else begin
        m_valid = instr_valid; m_mr = memread && instr_valid; m_rw = regwrite && instr_valid;
        m_dr1 = d1; m_dr2 = d2; m_imm = imm; m_rs = rs; m_rt = rt; m_dest = dst;
      end
    end
    check("ex_valid",    32'(ex_valid_o),    32'(m_valid));
    check("ex_memread",  32'(ex_memread_o),  32'(m_mr));
    check("ex_regwrite", 32'(ex_regwrite_o), 32'(m_rw));
    check("ex_dr1",      ex_dr1_o,           m_dr1);
    check("ex_dr2",      ex_dr2_o,           m_dr2);
    check("ex_imm",      ex_imm_o,           m_imm);
    check("ex_rs",       32'(ex_rs_o),       32'(m_rs));
    check("ex_rt",       32'(ex_rt_o),       32'(m_rt));
    check("ex_dest",     32'(ex_dest_o),     32'(m_dest));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    rst = 1'b1;
    drive(32'd0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 32'd0);

    // Reset state
    step();
    check("rst_valid", 32'(ex_valid_o), 32'd0);
    check("rst_dr1",   ex_dr1_o,        32'd0);
    rst = 1'b0;

    // Same-cycle write-back bypass
    drive(mk(5'd5, 5'd0, 16'h0), 1, 2'b00, 0, 1, 0, 1, 5'd5, 32'hDEADBEEF);
    step();
    check("byp_dr1", ex_dr1_o, 32'hDEADBEEF);

    // r0 is never written and rd=0 destination stays 0
    drive(mk(5'd0, 5'd3, 16'h0), 1, 2'b01, 0, 1, 0, 1, 5'd0, 32'h1234);
    step();
    drive(mk(5'd0, 5'd3, 16'h0), 1, 2'b01, 0, 1, 0, 0, 5'd0, 32'h0);
    step();
    check("r0_dr1",  ex_dr1_o,         32'd0);
    check("r0_dest", 32'(ex_dest_o),   32'd0);

    // Load-use: one bubble, then the dependent instruction issues
    drive(mk(5'd1, 5'd8, 16'h4), 1, 2'b00, 1, 1, 0, 0, 5'd0, 32'd0);
    step();
    drive(mk(5'd8, 5'd2, 16'h0), 1, 2'b00, 0, 1, 0, 0, 5'd0, 32'd0);
    #1 check("lu_stall", 32'(stall_o), 32'd1);
    step();
    check("lu_bubble", 32'(ex_valid_o), 32'd0);
    #1 check("lu_stall_clear", 32'(stall_o), 32'd0);
    step();
    check("lu_issue_valid", 32'(ex_valid_o), 32'd1);
    check("lu_issue_rs",    32'(ex_rs_o),    32'd8);

    // Load into r0 never stalls
    drive(mk(5'd1, 5'd0, 16'h0), 1, 2'b00, 1, 1, 0, 0, 5'd0, 32'd0);
    step();
    drive(mk(5'd0, 5'd0, 16'h0), 1, 2'b00, 0, 1, 0, 0, 5'd0, 32'd0);
    #1 check("r0_load_nostall", 32'(stall_o), 32'd0);
    step();

    // Flush together with a hazard
    drive(mk(5'd1, 5'd9, 16'h0), 1, 2'b00, 1, 1, 0, 0, 5'd0, 32'd0);
    step();
    drive(mk(5'd9, 5'd0, 16'h0), 1, 2'b00, 0, 1, 1, 0, 5'd0, 32'd0);
    #1 check("fl_stall", 32'(stall_o), 32'd0);
    step();
    check("fl_valid",    32'(ex_valid_o),    32'd0);
    check("fl_regwrite", 32'(ex_regwrite_o), 32'd0);

    // Link destination, negative immediate, reserved regdst
    drive(mk(5'd1, 5'd2, 16'h8000), 1, 2'b10, 0, 1, 0, 0, 5'd0, 32'd0);
    step();
    check("link_dest", 32'(ex_dest_o), 32'd31);
    check("imm_neg",   ex_imm_o,       32'hFFFF8000);
    drive(mk(5'd1, 5'd7, 16'hF800), 1, 2'b11, 0, 1, 0, 0, 5'd0, 32'd0);
    step();
    check("rsvd_dest", 32'(ex_dest_o), 32'd7);

    // Reset in the middle of a stall
    drive(32'd0, 0, 2'b00, 0, 0, 0, 1, 5'd10, 32'h55);
    step();
    drive(mk(5'd1, 5'd10, 16'h0), 1, 2'b00, 1, 1, 0, 0, 5'd0, 32'd0);
    step();
    drive(mk(5'd10, 5'd0, 16'h0), 1, 2'b00, 0, 1, 0, 0, 5'd0, 32'd0);
    #1 check("mid_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    #1 check("mid_rst_stall", 32'(stall_o), 32'd0);
    step();
    check("mid_rst_valid", 32'(ex_valid_o),   32'd0);
    check("mid_rst_mr",    32'(ex_memread_o), 32'd0);
    check("mid_rst_dest",  32'(ex_dest_o),    32'd0);
    rst = 1'b0;
    step();
    check("mid_rst_reg", ex_dr1_o, 32'd0);

    // Randomized traffic; a stalled instruction is held upstream
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      rst = ($urandom_range(0, 199) == 0);
      if (!m_stall_last) begin
        r = $urandom();
        instr       = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[15:0]);
        instr_valid = ($urandom_range(0, 9) != 0);
        regdst      = 2'($urandom_range(0, 3));
        memread     = ($urandom_range(0, 9) < 3);
        regwrite    = 1'($urandom());
      end
      flush   = ($urandom_range(0, 14) == 0);
      wb_we   = ($urandom_range(0, 2) != 0);
      wb_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 7));
      wb_data = $urandom();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_decode_stage_param
